var_delay15_align: RTL and testbench

Closed-loop tap controller for the `var_delay15` variable delay line. It drives the line's single-cycle `inc_pulse` input, and compares the line output (`dly_sig`) against a reference copy of the same stream (`ref_sig`). It scans all 16 taps, counts mismatches per tap, seeks to the best tap, then monitors lock. It sits beside `var_delay15`, shares its clock and reset, and is the only agent driving its `inc_pulse`.

---
 rtl/var_delay15_align.sv | 215 +++++++++++++++++++++
 tb/tb_var_delay15_align.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_delay15_align.sv
// rtl/var_delay15_align.sv - closed-loop tap scan, seek and lock monitor for var_delay15
//
// Scans all 16 taps of the attached var_delay15 starting from the current tap.
// For each tap it counts the cycles where ref_sig and dly_sig differ. It then
// steps the line to the first tap that gave the lowest count, and keeps checking
// that tap in back-to-back windows.
//
// Ports:
//   clk        clock shared with var_delay15
//   rst        synchronous active-high reset; must also reset var_delay15
//   start      begin a scan from IDLE, MONITOR or FAIL (ignored while busy)
//   ref_sig    reference stream
//   dly_sig    var_delay15.out_sig
//   inc_pulse  registered single-cycle increment to var_delay15.inc_pulse
//   tap        mirror of the delay-line length (0..15)
//   best_err   lowest window error count seen in the last scan
//   busy       high while scanning or seeking
//   locked     high while monitoring a good tap
//   fail       high after a scan found no acceptable tap, or after lock loss
//
// Optional macro VAR_DELAY15_AUTO_RELOCK_EN: when lock is lost, start a fresh
// scan automatically instead of going to FAIL.
module var_delay15_align #(
    parameter int WIN_LEN    = 64,
    parameter int ERR_TOL    = 0,
    parameter int SETTLE_CYC = 2,
    localparam int CW        = $clog2(WIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ref_sig,
    input  logic          dly_sig,
    output logic          inc_pulse,
    output logic [3:0]    tap,
    output logic [CW-1:0] best_err,
    output logic          busy,
    output logic          locked,
    output logic          fail
);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_STEP,
        S_SEEK,
        S_MONITOR,
        S_FAIL
    } state_t;

    state_t        state;
    logic [3:0]    best_tap;
    logic [3:0]    scan_idx;
    logic [CW-1:0] err;
    logic [CW-1:0] win_cnt;
    logic [SW-1:0] set_cnt;

    logic [CW-1:0] err_next;
    logic [3:0]    tap_next;
    logic          mis;
    logic          win_last;
    logic          set_last;
    logic          lost;
    logic          best_err_ok;
    logic          scan_go;

    assign mis         = ref_sig ^ dly_sig;
    assign win_last    = (win_cnt == CW'(WIN_LEN - 1));
    assign set_last    = (set_cnt == SW'(SETTLE_CYC - 1));
    // Delay line samples inc_pulse on the same edge that the mirror advances.
    assign tap_next    = tap + {3'd0, inc_pulse};
    assign lost        = int'(err_next) > ERR_TOL;
    assign best_err_ok = int'(best_err) <= ERR_TOL;

    // Error count including the current cycle, saturating at WIN_LEN.
    always_comb begin
        err_next = err;
        if (mis && (err != CW'(WIN_LEN))) begin
            err_next = err + 1'b1;
        end
    end

    // Conditions that open a new scan. This block overrides the per-state update below.
    always_comb begin
        scan_go = 1'b0;
        if (start && (state == S_IDLE || state == S_MONITOR || state == S_FAIL)) begin
            scan_go = 1'b1;
        end
`ifdef VAR_DELAY15_AUTO_RELOCK_EN
        if (state == S_MONITOR && win_last && lost) begin
            scan_go = 1'b1;
        end
`else
        if (state == S_IDLE && !start) begin
            scan_go = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            inc_pulse <= 1'b0;
            tap       <= 4'd0;
            best_err  <= '1;
            best_tap  <= 4'd0;
            scan_idx  <= 4'd0;
            err       <= '0;
            win_cnt   <= '0;
            set_cnt   <= '0;
            busy      <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            inc_pulse <= 1'b0;
            tap       <= tap_next;

            case (state)
                S_SETTLE: begin
                    if (set_last) begin
                        set_cnt <= '0;
                        err     <= '0;
                        win_cnt <= '0;
                        state   <= S_MEASURE;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end

                S_MEASURE: begin
                    if (win_last) begin
                        err     <= '0;
                        win_cnt <= '0;
                        // Strict compare: the first tap reaching the minimum is kept.
                        if (err_next < best_err) begin
                            best_err <= err_next;
                            best_tap <= tap;
                        end
                        if (scan_idx == 4'd15) begin
                            state <= S_SEEK;
                        end else begin
                            state     <= S_STEP;
                            inc_pulse <= 1'b1;
                        end
                    end else begin
                        err     <= err_next;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end

                S_STEP: begin
                    scan_idx <= scan_idx + 4'd1;
                    set_cnt  <= '0;
                    state    <= S_SETTLE;
                end

                S_SEEK: begin
                    // Look one pulse ahead so that back-to-back pulses stop on best_tap.
                    if (tap_next != best_tap) begin
                        inc_pulse <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        err     <= '0;
                        win_cnt <= '0;
                        if (best_err_ok) begin
                            state  <= S_MONITOR;
                            locked <= 1'b1;
                        end else begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end
                    end
                end

                S_MONITOR: begin
                    if (win_last) begin
                        err     <= '0;
                        win_cnt <= '0;
`ifdef VAR_DELAY15_AUTO_RELOCK_EN
                        // Lock loss is handled by the scan restart below.
`else
                        if (lost) begin
                            state  <= S_FAIL;
                            locked <= 1'b0;
                            fail   <= 1'b1;
                        end
`endif
                    end else begin
                        err     <= err_next;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end

                default: begin
                end
            endcase

            if (scan_go) begin
                state    <= S_SETTLE;
                best_err <= '1;
                best_tap <= tap_next;
                scan_idx <= 4'd0;
                set_cnt  <= '0;
                err      <= '0;
                win_cnt  <= '0;
                busy     <= 1'b1;
                locked   <= 1'b0;
                fail     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_var_delay15_align.sv
// tb/tb_var_delay15_align.sv - scoreboard bench for var_delay15_align with a delay-line model
`timescale 1ns/1ps
module tb_var_delay15_align;
    localparam int WIN_LEN    = 64;
    localparam int ERR_TOL    = 0;
    localparam int SETTLE_CYC = 2;
    localparam int CW         = $clog2(WIN_LEN + 1);
    localparam int SCAN_LEN   = 16 * (SETTLE_CYC + WIN_LEN) + 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ref_sig;
    logic          dly_sig;
    logic          inc_pulse;
    logic [3:0]    tap;
    logic [CW-1:0] best_err;
    logic          busy;
    logic          locked;
    logic          fail;

    var_delay15_align #(
        .WIN_LEN   (WIN_LEN),
        .ERR_TOL   (ERR_TOL),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ref_sig  (ref_sig),
        .dly_sig  (dly_sig),
        .inc_pulse(inc_pulse),
        .tap      (tap),
        .best_err (best_err),
        .busy     (busy),
        .locked   (locked),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    // Environment: LFSR stream, variable delay line and fixed D-cycle reference pipe.
    logic [15:0] lfsr   = 16'hACE1;
    logic [31:0] hist   = '0;
    logic [3:0]  vd_tap = '0;
    int          d_ref  = 0;
    int          mode   = 0;   // 0: LFSR, 1: inverted reference, 2: constant zero
    int          cyc    = 0;
    int          pulses = 0;

    always @(posedge clk) begin
        lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        hist   <= {hist[30:0], lfsr[15]};
        cyc    <= cyc + 1;
        if (inc_pulse) pulses <= pulses + 1;
        if (rst) vd_tap <= 4'd0;
        else if (inc_pulse) vd_tap <= vd_tap + 4'd1;
    end

    always_comb begin
        dly_sig = (mode == 2) ? 1'b0 : hist[vd_tap];
        case (mode)
            1:       ref_sig = ~dly_sig;
            2:       ref_sig = 1'b0;
            default: ref_sig = hist[d_ref];
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int tap;
        int locked;
        int fail;
        int berr;
        int lat;
        int npulse;
    } exp_t;

    exp_t sb[$];
    int   cur_tap      = 0;
    int   start_cyc    = 0;
    int   start_pulses = 0;

    // Reference model: only the true delay gives a zero-error window on the LFSR
    // stream; inverted or constant streams tie, so the scan-start tap wins.
    function automatic exp_t model(input int t0, input int m, input int d);
        exp_t e;
        int   best;
        int   berr;
        int   seek;
        if (m == 0) begin
            best = d;
            berr = 0;
        end else if (m == 1) begin
            best = t0;
            berr = WIN_LEN;
        end else begin
            best = t0;
            berr = 0;
        end
        seek     = (best - (t0 + 15)) & 15;
        e.tap    = best;
        e.locked = (berr <= ERR_TOL) ? 1 : 0;
        e.fail   = (berr <= ERR_TOL) ? 0 : 1;
        e.berr   = berr;
        e.lat    = SCAN_LEN + seek + 1;
        e.npulse = 15 + seek;
        return e;
    endfunction

    // Monitor: each end of a scan (busy falling outside reset) is checked against the queue.
    initial begin
        exp_t e;
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy && !rst) begin
                if (sb.size() == 0) begin
                    check("unexpected_scan_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("tap", int'(tap), e.tap);
                    check("locked", int'(locked), e.locked);
                    check("fail", int'(fail), e.fail);
                    check("best_err", int'(best_err), e.berr);
                    if (e.lat >= 0) check("latency", cyc - start_cyc, e.lat);
                    check("pulses", pulses - start_pulses, e.npulse);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({"done_timeout_", tag}, 0, 1);
            sb.delete();
        end
    endtask

    task automatic issue_start(input int m, input int d);
        @(posedge clk);
        #1;
        mode  = m;
        d_ref = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        start_cyc    = cyc;
        start_pulses = pulses;
    endtask

    task automatic run_scan(input int m, input int d, input string tag);
        exp_t e;
        e = model(cur_tap, m, d);
        issue_start(m, d);
        sb.push_back(e);
        wait_done(tag);
        cur_tap = e.tap;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cur_tap = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inc_pulse"}, int'(inc_pulse), 0);
        check({tag, "_tap"}, int'(tap), 0);
        check({tag, "_best_err"}, int'(best_err), (1 << CW) - 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_fail"}, int'(fail), 0);
    endtask

    initial begin
        int n;
        int p0;
        exp_t e;

        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        run_scan(0, 5, "d5");
        do_reset();
        run_scan(0, 0, "d0");
        do_reset();
        run_scan(1, 0, "inverted");
        run_scan(2, 0, "const0");

        repeat (3) run_scan(0, $urandom_range(0, 15), "random_d");

        // Lock at D=5, then move the reference to D=9 while monitoring.
        run_scan(0, 5, "relock_pre");
        repeat (10) @(posedge clk);
        #1;
        d_ref = 9;
        p0    = pulses;
`ifdef VAR_DELAY15_AUTO_RELOCK_EN
        e       = model(cur_tap, 0, 9);
        e.lat   = -1;
        start_pulses = p0;
        sb.push_back(e);
        wait_done("auto_relock");
        cur_tap = e.tap;
`else
        n = 0;
        while (!fail && n < WIN_LEN + 1) begin
            @(negedge clk);
            n++;
        end
        check("loss_fail", int'(fail), 1);
        check("loss_locked", int'(locked), 0);
        repeat (2 * WIN_LEN) @(negedge clk);
        check("loss_fail_held", int'(fail), 1);
        check("loss_tap_held", int'(tap), 5);
        check("loss_no_pulses", pulses - p0, 0);
`endif

        // Reset while a STEP pulse is in flight.
        issue_start(0, 3);
        n = 0;
        while (!(inc_pulse && busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("step_pulse_seen", int'(inc_pulse && busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_step_rst");
        rst     = 1'b0;
        cur_tap = 0;
        run_scan(0, 3, "after_rst_d3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
